// File: rtl/cache_pkg.sv
// Shared definitions for the cache / miss-handling slice: address field
// positions, MSHR state encoding and the memory word-address builder.
package cache_pkg;

  // Geometry of the 4-way cache line as seen by the memory side
  localparam int ADR_W    = 32;
  localparam int WORD_W   = 32;
  localparam int WORD_CNT = 4;
  localparam int WOFF_W   = 2;
  localparam int BOFF_W   = 2;
  localparam int LINE_W   = ADR_W - WOFF_W - BOFF_W;

  // Address field positions
  localparam int TAG_MSB  = 31;
  localparam int TAG_LSB  = 11;
  localparam int IDX_MSB  = 10;
  localparam int IDX_LSB  = 4;
  localparam int WOFF_MSB = 3;
  localparam int WOFF_LSB = 2;
  localparam int BOFF_MSB = 1;
  localparam int BOFF_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CAPTURE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_FETCH     = 2'd3
  } mshr_state_e;

  // Memory word address of word 'word' within line 'line' (byte offset zero)
  function automatic logic [ADR_W-1:0] word_adr(input logic [LINE_W-1:0] line,
                                                input logic [WOFF_W-1:0] word);
    word_adr = {line, word, {BOFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/mshr_line_buf.sv
// One-line staging buffer for the victim line: per-word write port,
// received-word mask, synchronous clear and combinational read port.
module mshr_line_buf
  import cache_pkg::*;
#(
  parameter int WORD_WIDTH        = 32,
  parameter int WORD_NUM          = 4,
  parameter int WORD_OFFSET_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clr,
  input  logic                         i_we,
  input  logic [WORD_OFFSET_WIDTH-1:0] i_widx,
  input  logic [WORD_WIDTH-1:0]        i_wdat,
  input  logic [WORD_OFFSET_WIDTH-1:0] i_ridx,
  output logic [WORD_WIDTH-1:0]        o_rdat,
  output logic [WORD_NUM-1:0]          o_mask
);

  logic [WORD_WIDTH-1:0] r_mem [WORD_NUM];
  logic [WORD_NUM-1:0]   r_mask;

  // Word storage and received mask; clear wins over a same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORD_NUM; i++) r_mem[i] <= {WORD_WIDTH{1'b0}};
      r_mask <= {WORD_NUM{1'b0}};
    end else if (i_clr) begin
      for (int i = 0; i < WORD_NUM; i++) r_mem[i] <= {WORD_WIDTH{1'b0}};
      r_mask <= {WORD_NUM{1'b0}};
    end else if (i_we) begin
      r_mem[i_widx]  <= i_wdat;
      r_mask[i_widx] <= 1'b1;
    end
  end

  assign o_rdat = r_mem[i_ridx];
  assign o_mask = r_mask;

endmodule

// File: rtl/cache_mshr.sv
// Miss-status holding register: captures a dirty victim line, writes it back
// word by word, then fetches the missing line critical-word-first and streams
// each word to the cache. One outstanding miss at a time.
module cache_mshr
  import cache_pkg::*;
#(
  parameter int ADR_WIDTH         = 32,
  parameter int WORD_WIDTH        = 32,
  parameter int WORD_NUM          = 4,
  parameter int WORD_OFFSET_WIDTH = 2,
  parameter int BYTE_OFFSET_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         miss_req_i,
  input  logic [ADR_WIDTH-1:0]         miss_adr_i,
  input  logic                         victim_dirty_i,
  input  logic [ADR_WIDTH-1:0]         victim_adr_i,
  input  logic                         victim_we_i,
  input  logic [WORD_OFFSET_WIDTH-1:0] victim_word_i,
  input  logic [WORD_WIDTH-1:0]        victim_dat_i,
  output logic                         busy_o,
  output logic                         refill_valid_o,
  output logic [WORD_OFFSET_WIDTH-1:0] refill_word_o,
  output logic [WORD_WIDTH-1:0]        refill_dat_o,
  output logic                         refill_done_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [ADR_WIDTH-1:0]         mem_adr_o,
  output logic [WORD_WIDTH-1:0]        mem_dat_o,
  input  logic                         mem_ack_i,
  input  logic [WORD_WIDTH-1:0]        mem_dat_i
);

  localparam int LINE_WIDTH = ADR_WIDTH - WORD_OFFSET_WIDTH - BYTE_OFFSET_WIDTH;

  mshr_state_e                  r_state;
  mshr_state_e                  w_state_nxt;
  logic [LINE_WIDTH-1:0]        r_miss_line;
  logic [LINE_WIDTH-1:0]        r_vic_line;
  logic [WORD_OFFSET_WIDTH-1:0] r_crit;
  logic [WORD_OFFSET_WIDTH-1:0] r_cnt;
  logic [WORD_OFFSET_WIDTH-1:0] w_cnt_nxt;
  logic                         r_refill_valid;
  logic                         r_refill_done;
  logic [WORD_OFFSET_WIDTH-1:0] r_refill_word;
  logic [WORD_WIDTH-1:0]        r_refill_dat;

  logic                         w_accept;
  logic                         w_buf_we;
  logic                         w_fetch_ack;
  logic                         w_last;
  logic [WORD_NUM-1:0]          w_we_onehot;
  logic [WORD_NUM-1:0]          w_mask;
  logic [WORD_WIDTH-1:0]        w_rdat;
  logic [WORD_OFFSET_WIDTH-1:0] w_fetch_word;
  logic                         w_unused_adr;

  // Offset bits of the victim address and byte bits of the miss address carry no information here
  assign w_unused_adr = ^{miss_adr_i[BOFF_MSB:BOFF_LSB],
                          victim_adr_i[WORD_OFFSET_WIDTH+BYTE_OFFSET_WIDTH-1:0]};

  assign w_last       = (r_cnt == {WORD_OFFSET_WIDTH{1'b1}});
  assign w_fetch_word = r_crit + r_cnt;   // wraps modulo the line size

  mshr_line_buf #(
    .WORD_WIDTH        (WORD_WIDTH),
    .WORD_NUM          (WORD_NUM),
    .WORD_OFFSET_WIDTH (WORD_OFFSET_WIDTH)
  ) u_line_buf (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_accept),
    .i_we   (w_buf_we),
    .i_widx (victim_word_i),
    .i_wdat (victim_dat_i),
    .i_ridx (r_cnt),
    .o_rdat (w_rdat),
    .o_mask (w_mask)
  );

  // One-hot of the victim word strobed this cycle, so the full test sees it immediately
  always_comb begin
    w_we_onehot = {WORD_NUM{1'b0}};
    if (victim_we_i) begin
      w_we_onehot = {{(WORD_NUM-1){1'b0}}, 1'b1} << victim_word_i;
    end else begin
      w_we_onehot = {WORD_NUM{1'b0}};
    end
  end

  // Next-state, word counter and datapath enables
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_buf_we    = 1'b0;
    w_fetch_ack = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (miss_req_i) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = {WORD_OFFSET_WIDTH{1'b0}};
          w_state_nxt = victim_dirty_i ? ST_CAPTURE : ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        w_buf_we = victim_we_i;
        if (&(w_mask | w_we_onehot)) begin
          w_state_nxt = ST_WRITEBACK;
        end else begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_WRITEBACK: begin
        if (mem_ack_i) begin
          w_cnt_nxt   = r_cnt + {{(WORD_OFFSET_WIDTH-1){1'b0}}, 1'b1};
          w_state_nxt = w_last ? ST_FETCH : ST_WRITEBACK;
        end else begin
          w_state_nxt = ST_WRITEBACK;
        end
      end
      ST_FETCH: begin
        if (mem_ack_i) begin
          w_fetch_ack = 1'b1;
          w_cnt_nxt   = r_cnt + {{(WORD_OFFSET_WIDTH-1){1'b0}}, 1'b1};
          w_state_nxt = w_last ? ST_IDLE : ST_FETCH;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {WORD_OFFSET_WIDTH{1'b0}};
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Word counter; wraps to zero after the last word of each phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= {WORD_OFFSET_WIDTH{1'b0}};
    else     r_cnt <= w_cnt_nxt;
  end

  // Miss context latched when a miss is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_miss_line <= {LINE_WIDTH{1'b0}};
      r_vic_line  <= {LINE_WIDTH{1'b0}};
      r_crit      <= {WORD_OFFSET_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_miss_line <= miss_adr_i[ADR_WIDTH-1:WORD_OFFSET_WIDTH+BYTE_OFFSET_WIDTH];
      r_vic_line  <= victim_adr_i[ADR_WIDTH-1:WORD_OFFSET_WIDTH+BYTE_OFFSET_WIDTH];
      r_crit      <= miss_adr_i[WOFF_MSB:WOFF_LSB];
    end
  end

  // Refill stream to the cache; data holds its last value between words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refill_valid <= 1'b0;
      r_refill_done  <= 1'b0;
      r_refill_word  <= {WORD_OFFSET_WIDTH{1'b0}};
      r_refill_dat   <= {WORD_WIDTH{1'b0}};
    end else begin
      r_refill_valid <= w_fetch_ack;
      r_refill_done  <= w_fetch_ack & w_last;
      if (w_fetch_ack) begin
        r_refill_word <= w_fetch_word;
        r_refill_dat  <= mem_dat_i;
      end
    end
  end

  // Memory port decode from the registered state
  always_comb begin
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_adr_o = {ADR_WIDTH{1'b0}};
    mem_dat_o = {WORD_WIDTH{1'b0}};
    case (r_state)
      ST_WRITEBACK: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        mem_adr_o = word_adr(r_vic_line, r_cnt);
        mem_dat_o = w_rdat;
      end
      ST_FETCH: begin
        mem_req_o = 1'b1;
        mem_adr_o = word_adr(r_miss_line, w_fetch_word);
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
  end

  assign busy_o         = (r_state != ST_IDLE);
  assign refill_valid_o = r_refill_valid;
  assign refill_done_o  = r_refill_done;
  assign refill_word_o  = r_refill_word;
  assign refill_dat_o   = r_refill_dat;

endmodule

// File: tb/tb_cache_mshr.sv
// Directed bench for cache_mshr: table of miss scenarios with hand-computed
// memory traffic and refill streams, plus hand sequences for reset and
// spurious-handshake corner cases. A small memory responder logs requests.
module tb_cache_mshr;

  logic        clk;
  logic        rst;
  logic        miss_req_i;
  logic [31:0] miss_adr_i;
  logic        victim_dirty_i;
  logic [31:0] victim_adr_i;
  logic        victim_we_i;
  logic [1:0]  victim_word_i;
  logic [31:0] victim_dat_i;
  logic        busy_o;
  logic        refill_valid_o;
  logic [1:0]  refill_word_o;
  logic [31:0] refill_dat_o;
  logic        refill_done_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic        mem_ack_i;
  logic [31:0] mem_dat_i;

  cache_mshr dut (
    .clk            (clk),
    .rst            (rst),
    .miss_req_i     (miss_req_i),
    .miss_adr_i     (miss_adr_i),
    .victim_dirty_i (victim_dirty_i),
    .victim_adr_i   (victim_adr_i),
    .victim_we_i    (victim_we_i),
    .victim_word_i  (victim_word_i),
    .victim_dat_i   (victim_dat_i),
    .busy_o         (busy_o),
    .refill_valid_o (refill_valid_o),
    .refill_word_o  (refill_word_o),
    .refill_dat_o   (refill_dat_o),
    .refill_done_o  (refill_done_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_adr_o      (mem_adr_o),
    .mem_dat_o      (mem_dat_o),
    .mem_ack_i      (mem_ack_i),
    .mem_dat_i      (mem_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder log
  logic [31:0] ml_adr [256];
  logic        ml_we  [256];
  logic [31:0] ml_dat [256];
  int          n_mem = 0;
  int          stab_viol = 0;
  int          wait_cfg = 0;
  bit          spurious = 1'b0;

  // Refill monitor log
  logic [1:0]  rl_word [256];
  logic [31:0] rl_dat  [256];
  logic        rl_done [256];
  logic        rl_busy [256];
  int          rl_cyc  [256];
  int          n_ref = 0;
  int          stray_done = 0;

  // Memory model: acks after wait_cfg stall cycles, read data = 0xA0 + word index
  initial begin
    int          mcnt;
    logic [31:0] h_adr;
    logic [31:0] h_dat;
    logic        h_we;
    mcnt = 0; h_adr = 32'h0; h_dat = 32'h0; h_we = 1'b0;
    mem_ack_i = 1'b0;
    mem_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_ack_i = 1'b0;
        mcnt = 0;
      end else if (mem_req_o) begin
        if (mcnt == 0) begin
          h_adr = mem_adr_o; h_we = mem_we_o; h_dat = mem_dat_o;
        end else if (mem_adr_o !== h_adr || mem_we_o !== h_we || mem_dat_o !== h_dat) begin
          stab_viol++;
        end
        mem_dat_i = 32'hA0 + {28'h0, 2'b00, mem_adr_o[3:2]};
        if (mcnt >= wait_cfg) begin
          mem_ack_i = 1'b1;
          if (n_mem < 256) begin
            ml_adr[n_mem] = mem_adr_o; ml_we[n_mem] = mem_we_o; ml_dat[n_mem] = mem_dat_o;
          end
          n_mem++;
          mcnt = 0;
        end else begin
          mem_ack_i = 1'b0;
          mcnt++;
        end
      end else begin
        mem_ack_i = spurious;
        mem_dat_i = 32'h5A;
        mcnt = 0;
      end
    end
  end

  // Refill monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && refill_valid_o) begin
        if (n_ref < 256) begin
          rl_word[n_ref] = refill_word_o; rl_dat[n_ref] = refill_dat_o;
          rl_done[n_ref] = refill_done_o; rl_busy[n_ref] = busy_o; rl_cyc[n_ref] = cyc;
        end
        n_ref++;
      end else if (!rst && refill_done_o) begin
        stray_done++;
      end
    end
  end

  typedef struct {
    logic [31:0] miss_adr;
    logic        dirty;
    logic [31:0] vic_adr;
    int          wait_c;
    int          nstb;
    logic [1:0]  stb_idx [5];
    logic [31:0] stb_dat [5];
    logic        poke;
    logic        spur;
    logic [31:0] wadr [4];
    logic [31:0] wdat [4];
    logic [31:0] radr [4];
    logic [1:0]  rword [4];
    logic [31:0] rdat [4];
  } scen_t;

  scen_t scen [5];

  task automatic run_scen(input int id, input scen_t s, input bit lat);
    int bm, br, sv0, ic, t, nw, nr;
    bit order_err, seen_read;
    bm = n_mem; br = n_ref; sv0 = stab_viol;
    wait_cfg = s.wait_c;
    @(negedge clk);
    miss_req_i = 1'b1; miss_adr_i = s.miss_adr; victim_dirty_i = s.dirty; victim_adr_i = s.vic_adr;
    @(negedge clk);
    miss_req_i = 1'b0; victim_dirty_i = 1'b0;
    miss_adr_i = 32'hFFFF_FFFC; victim_adr_i = 32'hEEEE_EEE0;
    ic = cyc;
    chk($sformatf("s%0d_busy_after_req", id), {31'h0, busy_o}, 32'h1);
    if (s.dirty) begin
      for (int i = 0; i < s.nstb; i++) begin
        victim_we_i = 1'b1; victim_word_i = s.stb_idx[i]; victim_dat_i = s.stb_dat[i];
        @(negedge clk);
      end
      victim_we_i = 1'b0;
    end
    if (s.poke) begin
      chk($sformatf("s%0d_busy_at_poke", id), {31'h0, busy_o}, 32'h1);
      miss_req_i = 1'b1; miss_adr_i = 32'h0000_F000; victim_dirty_i = 1'b1;
      @(negedge clk);
      miss_req_i = 1'b0; victim_dirty_i = 1'b0;
    end
    if (s.spur) begin
      t = 0;
      while (!(mem_req_o && !mem_we_o) && t < 100) begin
        @(negedge clk);
        t++;
      end
      victim_we_i = 1'b1; victim_word_i = 2'd0; victim_dat_i = 32'hEE;
      @(negedge clk);
      victim_we_i = 1'b0;
    end
    t = 0;
    while ((n_ref - br) < 4 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("s%0d_timeout", id), {31'h0, (t < 400)}, 32'h1);
    repeat (3) @(negedge clk);

    nw = 0; nr = 0; order_err = 1'b0; seen_read = 1'b0;
    for (int i = bm; i < n_mem && i < 256; i++) begin
      if (ml_we[i]) begin
        if (seen_read) order_err = 1'b1;
        if (nw < 4) begin
          chk($sformatf("s%0d_wr%0d_adr", id, nw), ml_adr[i], s.wadr[nw]);
          chk($sformatf("s%0d_wr%0d_dat", id, nw), ml_dat[i], s.wdat[nw]);
        end
        nw++;
      end else begin
        seen_read = 1'b1;
        if (nr < 4) chk($sformatf("s%0d_rd%0d_adr", id, nr), ml_adr[i], s.radr[nr]);
        nr++;
      end
    end
    chk($sformatf("s%0d_write_count", id), nw, s.dirty ? 32'd4 : 32'd0);
    chk($sformatf("s%0d_read_count", id), nr, 32'd4);
    chk($sformatf("s%0d_write_before_read", id), {31'h0, order_err}, 32'h0);
    chk($sformatf("s%0d_refill_count", id), n_ref - br, 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (br + k < n_ref) begin
        chk($sformatf("s%0d_ref%0d_word", id, k), {30'h0, rl_word[br+k]}, {30'h0, s.rword[k]});
        chk($sformatf("s%0d_ref%0d_dat", id, k), rl_dat[br+k], s.rdat[k]);
        chk($sformatf("s%0d_ref%0d_done", id, k), {31'h0, rl_done[br+k]}, (k == 3) ? 32'h1 : 32'h0);
        if (k == 3) chk($sformatf("s%0d_busy_at_done", id), {31'h0, rl_busy[br+k]}, 32'h0);
      end
    end
    if (lat && (n_ref - br) >= 4) begin
      chk($sformatf("s%0d_first_refill_cycle", id), rl_cyc[br] - ic, 32'd1);
      chk($sformatf("s%0d_done_cycle", id), rl_cyc[br+3] - ic, 32'd4);
    end
    chk($sformatf("s%0d_addr_data_stable", id), stab_viol - sv0, 32'd0);
    chk($sformatf("s%0d_valid_low_after", id), {31'h0, refill_valid_o}, 32'h0);
    chk($sformatf("s%0d_dat_holds", id), refill_dat_o, s.rdat[3]);
    chk($sformatf("s%0d_idle_after", id), {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    int bm, br, t;
    // fields: miss_adr, dirty, vic_adr, wait, nstb, stb_idx, stb_dat, poke, spur,
    //         wadr, wdat, radr, rword, rdat
    scen[0] = '{32'h0000_1238, 1'b0, 32'h0, 0, 0, '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b0,
                '{32'h0, 32'h0, 32'h0, 32'h0}, '{32'h0, 32'h0, 32'h0, 32'h0},
                '{32'h1238, 32'h123C, 32'h1230, 32'h1234}, '{2'd2, 2'd3, 2'd0, 2'd1},
                '{32'hA2, 32'hA3, 32'hA0, 32'hA1}};
    scen[1] = '{32'h0000_2204, 1'b1, 32'h0000_4560, 0, 4, '{2'd3, 2'd1, 2'd0, 2'd2, 2'd0},
                '{32'hD3, 32'hD1, 32'hD0, 32'hD2, 32'h0}, 1'b0, 1'b0,
                '{32'h4560, 32'h4564, 32'h4568, 32'h456C}, '{32'hD0, 32'hD1, 32'hD2, 32'hD3},
                '{32'h2204, 32'h2208, 32'h220C, 32'h2200}, '{2'd1, 2'd2, 2'd3, 2'd0},
                '{32'hA1, 32'hA2, 32'hA3, 32'hA0}};
    scen[2] = '{32'h0000_300C, 1'b1, 32'h0000_777C, 3, 4, '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0},
                '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'h0}, 1'b1, 1'b0,
                '{32'h7770, 32'h7774, 32'h7778, 32'h777C}, '{32'hB0, 32'hB1, 32'hB2, 32'hB3},
                '{32'h300C, 32'h3000, 32'h3004, 32'h3008}, '{2'd3, 2'd0, 2'd1, 2'd2},
                '{32'hA3, 32'hA0, 32'hA1, 32'hA2}};
    scen[3] = '{32'h0000_1000, 1'b1, 32'h0000_8880, 0, 5, '{2'd1, 2'd0, 2'd1, 2'd2, 2'd3},
                '{32'h11, 32'hC0, 32'h22, 32'hC2, 32'hC3}, 1'b0, 1'b1,
                '{32'h8880, 32'h8884, 32'h8888, 32'h888C}, '{32'hC0, 32'h22, 32'hC2, 32'hC3},
                '{32'h1000, 32'h1004, 32'h1008, 32'h100C}, '{2'd0, 2'd1, 2'd2, 2'd3},
                '{32'hA0, 32'hA1, 32'hA2, 32'hA3}};
    scen[4] = '{32'h0000_ABC4, 1'b0, 32'h0, 1, 0, '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
                '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b0,
                '{32'h0, 32'h0, 32'h0, 32'h0}, '{32'h0, 32'h0, 32'h0, 32'h0},
                '{32'hABC4, 32'hABC8, 32'hABCC, 32'hABC0}, '{2'd1, 2'd2, 2'd3, 2'd0},
                '{32'hA1, 32'hA2, 32'hA3, 32'hA0}};

    rst = 1'b0;
    miss_req_i = 1'b0; miss_adr_i = 32'h0; victim_dirty_i = 1'b0; victim_adr_i = 32'h0;
    victim_we_i = 1'b0; victim_word_i = 2'd0; victim_dat_i = 32'h0;
    #1 rst = 1'b1;
    #2;
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_we", {31'h0, mem_we_o}, 32'h0);
    chk("rst_adr", mem_adr_o, 32'h0);
    chk("rst_refill_valid", {31'h0, refill_valid_o}, 32'h0);
    chk("rst_refill_done", {31'h0, refill_done_o}, 32'h0);
    chk("rst_refill_dat", refill_dat_o, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_scen(i, scen[i], (i == 0));

    // Reset in the middle of a writeback, after two accepted words
    wait_cfg = 0;
    bm = n_mem;
    @(negedge clk);
    miss_req_i = 1'b1; miss_adr_i = 32'h0000_2204; victim_dirty_i = 1'b1; victim_adr_i = 32'h0000_4560;
    @(negedge clk);
    miss_req_i = 1'b0; victim_dirty_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      victim_we_i = 1'b1; victim_word_i = i[1:0]; victim_dat_i = 32'h90 + i;
      @(negedge clk);
    end
    victim_we_i = 1'b0;
    t = 0;
    while ((n_mem - bm) < 2 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("rstwb_timeout", {31'h0, (t < 100)}, 32'h1);
    chk("rstwb_wr1_adr", ml_adr[(bm + 1) % 256], 32'h4564);
    chk("rstwb_wr1_dat", ml_dat[(bm + 1) % 256], 32'h91);
    #2 rst = 1'b1;
    #1;
    chk("rstwb_busy", {31'h0, busy_o}, 32'h0);
    chk("rstwb_req", {31'h0, mem_req_o}, 32'h0);
    chk("rstwb_we", {31'h0, mem_we_o}, 32'h0);
    chk("rstwb_adr", mem_adr_o, 32'h0);
    chk("rstwb_dat", mem_dat_o, 32'h0);
    chk("rstwb_refill_valid", {31'h0, refill_valid_o}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    br = n_ref; bm = n_mem;
    spurious = 1'b1;
    repeat (4) @(negedge clk);
    chk("spur_ack_busy", {31'h0, busy_o}, 32'h0);
    chk("spur_ack_req", {31'h0, mem_req_o}, 32'h0);
    spurious = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_ack_no_refill", n_ref - br, 32'd0);
    chk("spur_ack_no_mem", n_mem - bm, 32'd0);

    run_scen(5, scen[0], 1'b1);
    chk("stray_done", stray_done, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_mshr.md
Name: cache_mshr

Overview:
- Miss-status holding register on the memory side of the 4-way cache; it is the responder for the cache's miss/victim/refill interface.
- On a miss it captures the victim line (if dirty) and writes it back to memory. It then fetches the missing line critical-word-first.
- Each refill word is forwarded to the cache as it arrives, with a word index, and completion is signalled at the end.
- One outstanding miss at a time; sits between cache4way and the word-wide memory port.

Parameters:
ADR_WIDTH, 32, address width
WORD_WIDTH, 32, data word width
WORD_NUM, 4, words per cache line
WORD_OFFSET_WIDTH, 2, log2(WORD_NUM)
BYTE_OFFSET_WIDTH, 2, byte offset bits in address

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
miss_req_i  in  1  miss start pulse, sampled only in IDLE
miss_adr_i  in  ADR_WIDTH  missing address; word offset selects critical word
victim_dirty_i  in  1  victim line needs writeback, sampled with miss_req_i
victim_adr_i  in  ADR_WIDTH  victim line address (offset bits ignored), sampled with miss_req_i
victim_we_i  in  1  victim word strobe
victim_word_i  in  WORD_OFFSET_WIDTH  victim word index
victim_dat_i  in  WORD_WIDTH  victim word data
busy_o  out  1  miss in progress
refill_valid_o  out  1  refill word valid, one cycle
refill_word_o  out  WORD_OFFSET_WIDTH  refill word index
refill_dat_o  out  WORD_WIDTH  refill word data
refill_done_o  out  1  pulse with last refill word
mem_req_o  out  1  memory word request
mem_we_o  out  1  1 = write, 0 = read
mem_adr_o  out  ADR_WIDTH  word address, byte offset 0
mem_dat_o  out  WORD_WIDTH  write data
mem_ack_i  in  1  word accepted; read data valid this cycle
mem_dat_i  in  WORD_WIDTH  read data

Behaviour:
- Reset (async, any state):
  - state = IDLE; counters, mask and line buffer cleared.
  - All outputs 0, including busy_o, mem_req_o, refill_*.
  - Any in-flight memory word is abandoned; mem_ack_i arriving afterwards is ignored.
- States: IDLE, CAPTURE, WRITEBACK, FETCH.
- IDLE:
  - On miss_req_i, latch miss line, critical word w = miss_adr_i[3:2], victim line and dirty flag.
  - Next state is CAPTURE if dirty, else FETCH.
  - busy_o = 1 from the next cycle.
- CAPTURE:
  - Each victim_we_i writes buf[victim_word_i]; the word's bit is set in a 4-bit received mask.
  - Any arrival order is legal; a repeated index overwrites.
  - When the mask is 1111 (including the strobe of the current cycle), the next state is WRITEBACK.
  - victim_we_i in any other state is ignored.
- WRITEBACK:
  - mem_req_o = 1, mem_we_o = 1, mem_adr_o = {victim line, k, 2'b00}, mem_dat_o = buf[k], for k = 0..3 in order.
  - Address and data are held stable until mem_ack_i.
  - On ack, k advances the next cycle and req stays high.
  - On the ack for k = 3, the next state is FETCH and the counter is cleared.
- FETCH:
  - mem_req_o = 1, mem_we_o = 0, mem_adr_o = {miss line, (w+j) mod 4, 2'b00}, j = 0..3. Word index wraps modulo 4.
  - On ack, mem_dat_i is registered: the next cycle refill_valid_o = 1, refill_word_o = (w+j) mod 4, refill_dat_o = data.
  - On the ack for j = 3: next state IDLE, mem_req_o = 0 next cycle, and the final refill_valid_o coincides with refill_done_o = 1.
  - busy_o = 0 in that same cycle.
- Latency (zero-wait memory, ack in first req cycle):
  - Clean miss: req high cycles 1–4, refill words cycles 2–5, done in cycle 5.
  - Dirty miss: adds 4 write cycles plus capture time.
- Handshake rules:
  - mem_req_o drops only on leaving FETCH/WRITEBACK.
  - mem_ack_i while mem_req_o = 0 is ignored.
  - miss_req_i while busy is ignored (the cache must not issue it).
  - Memory wait states stall indefinitely with no timeout.
- Outputs not listed for a state are 0; refill_dat_o holds its last value and is qualified by valid.

Decomposition:
- Shared package cache_pkg holds:
  - Address-field positions (tag 31:11, index 10:4, word offset 3:2, byte offset 1:0).
  - The state encoding for IDLE/CAPTURE/WRITEBACK/FETCH.
  - A line-address helper function.
- One sub-module: mshr_line_buf, a 4×WORD_WIDTH register file with write port, received mask, clear, and combinational read port.

Test Plan:
- Clean miss, miss_adr_i = 0x0000_1238 (w = 2), zero-wait memory returning 0xA0+index -> mem_adr_o 0x1238, 0x123C, 0x1230, 0x1234; refill words 2, 3, 0, 1 with data 0xA2, 0xA3, 0xA0, 0xA1; done with word 1; busy_o low the same cycle.
- Dirty miss, victim_adr_i = 0x0000_4560, victim words delivered in order 3, 1, 0, 2 with data 0xD3, 0xD1, 0xD0, 0xD2 -> writes to 0x4560–0x456C in order with data 0xD0..0xD3, then fetch starts.
- Memory wait states: ack after 3 cycles on every word -> address and data stable while waiting, exactly 4 acks consumed per phase, no duplicate refill_valid_o.
- Victim word 1 strobed twice (0x11 then 0x22) -> writeback of word 1 carries 0x22; spurious victim_we_i in FETCH -> no effect.
- Async reset asserted mid-WRITEBACK after 2 acks -> all outputs 0 immediately; a later mem_ack_i is ignored; a new clean miss completes normally.
- miss_req_i pulsed while busy_o = 1 -> ignored; spurious mem_ack_i in IDLE -> no refill output.
